// File: rtl/axis_pixel_transmitter_if.sv
// AXI4-Stream video channel: pixel data plus start-of-frame (tuser) and
// end-of-line (tlast) markers.
interface axis_pixel_transmitter_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tuser;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/axis_pixel_transmitter.sv
// Pixel-stream to AXI4-Stream video bridge. Tags each accepted pixel with
// frame/line markers from column/row counters and buffers it in a small FIFO
// so the sink may stall; pixels arriving while the buffer is full are dropped
// but still counted so the line geometry stays aligned.
module axis_pixel_transmitter #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [12:0]           IMAGE_WIDTH,
    input  logic [12:0]           IMAGE_HEIGHT,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_data_valid,
    input  logic                  i_start_of_frame,
    axis_pixel_transmitter_if.master m_axis,
    output logic                  o_overflow,
    output logic                  o_frame_done
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, STREAM} state_t;

    // eof marks the last beat of the last line so frame_done follows the
    // beat out of the buffer rather than the pixel into it.
    typedef struct packed {
        logic                  eof;
        logic                  tuser;
        logic                  tlast;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    state_t      state_q, state_d;
    logic [12:0] col_q, col_d, row_q, row_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic        ovf_q, ovf_d;
    entry_t      mem_q [FIFO_DEPTH];

    logic [12:0] w_eff, h_eff, pix_col, pix_row;
    logic        empty, full, pop, take, push, pix_last, pix_eof;
    entry_t      head, wr_entry;

    // Pixel tagging, FIFO pointer arithmetic and next-state selection
    always_comb begin
        w_eff    = (IMAGE_WIDTH  == 13'd0) ? 13'd1 : IMAGE_WIDTH;
        h_eff    = (IMAGE_HEIGHT == 13'd0) ? 13'd1 : IMAGE_HEIGHT;
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        head     = mem_q[rd_ptr_q[AW-1:0]];
        pop      = !empty && m_axis.tready;
        // SOF is honoured in either state; in STREAM it restarts the frame.
        take     = i_data_valid && ((state_q == STREAM) || i_start_of_frame);
        // A same-cycle pop frees a slot, so a full buffer can still accept.
        push     = take && (!full || pop);
        pix_col  = i_start_of_frame ? 13'd0 : col_q;
        pix_row  = i_start_of_frame ? 13'd0 : row_q;
        pix_last = (pix_col == w_eff - 13'd1);
        pix_eof  = pix_last && (pix_row == h_eff - 13'd1);

        wr_entry.eof   = pix_eof;
        wr_entry.tuser = i_start_of_frame;
        wr_entry.tlast = pix_last;
        wr_entry.data  = i_data;

        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        ovf_d    = ovf_q | (take & ~push);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
        // Counters move on every accepted pixel, dropped or not.
        if (take) begin
            col_d   = pix_last ? 13'd0 : pix_col + 13'd1;
            row_d   = pix_last ? pix_row + 13'd1 : pix_row;
            state_d = pix_eof ? IDLE : STREAM;
        end
    end

    // State, counters, pointers and the sticky overflow flag
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= IDLE;
            col_q    <= '0;
            row_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    // Buffer storage; contents are only visible while non-empty, so no reset
    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
    end

    // Head entry drives the stream; outputs read zero while empty
    always_comb begin
        m_axis.tvalid = !empty;
        m_axis.tdata  = empty ? '0 : head.data;
        m_axis.tuser  = !empty && head.tuser;
        m_axis.tlast  = !empty && head.tlast;
        o_overflow    = ovf_q;
        o_frame_done  = pop && head.eof;
    end
endmodule

// File: tb/tb_axis_pixel_transmitter.sv
// Bench for axis_pixel_transmitter (FIFO_DEPTH=4): table-driven basic frame,
// directed corner sequences and randomized traffic against a frame-position
// model of the expected output stream.
module tb_axis_pixel_transmitter;
    localparam int DEPTH = 4;

    typedef struct {
        logic [7:0] d;
        logic       u, l, e;
    } beat_t;

    typedef struct {
        logic       v, s;
        logic [7:0] d;
        logic       tv;
        logic [7:0] td;
        logic       tu, tl, fd;
    } vec_t;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic [12:0] IMAGE_WIDTH = 13'd4, IMAGE_HEIGHT = 13'd2;
    logic [7:0]  i_data = '0;
    logic        i_data_valid = 1'b0, i_start_of_frame = 1'b0;
    logic        o_overflow, o_frame_done;

    axis_pixel_transmitter_if #(.DATA_WIDTH(8)) m_axis ();

    axis_pixel_transmitter #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .IMAGE_WIDTH(IMAGE_WIDTH), .IMAGE_HEIGHT(IMAGE_HEIGHT),
        .i_data(i_data), .i_data_valid(i_data_valid), .i_start_of_frame(i_start_of_frame),
        .m_axis(m_axis), .o_overflow(o_overflow), .o_frame_done(o_frame_done)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0, failures = 0;

    // reference model: expected buffer contents and position within frame
    beat_t q[$];
    beat_t got[$];
    int    m_pos, m_w, m_h;
    bit    m_stream, m_ovf;

    logic [7:0] obs_td;
    logic       obs_tv, obs_tu, obs_tl, obs_fd;

    vec_t tbl[10];
    int   e34[6] = '{21, 22, 23, 24, 27, 28};
    bit   l34[6] = '{0, 0, 0, 1, 0, 1};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit v, input bit s, input logic [7:0] d, input bit r);
        bit    pop, take, push;
        beat_t b;
        pop  = (q.size() > 0) && r;
        take = v && (m_stream || s);
        push = 0;
        if (take) begin
            if (s) m_pos = 0;
            b.d = d;
            b.u = s;
            b.l = (m_pos % m_w) == m_w - 1;
            b.e = (m_pos == m_w * m_h - 1);
            push = (q.size() < DEPTH) || pop;
            if (!push) m_ovf = 1;
            m_stream = !b.e;
            m_pos++;
        end
        if (pop) void'(q.pop_front());
        if (push) q.push_back(b);
    endtask

    // one clock: drive at negedge, compare just after, advance model, next negedge
    task automatic cyc(input bit v, input bit s, input logic [7:0] d, input bit r);
        i_data_valid = v; i_start_of_frame = s; i_data = d; m_axis.tready = r;
        #1;
        obs_tv = m_axis.tvalid; obs_td = m_axis.tdata; obs_tu = m_axis.tuser;
        obs_tl = m_axis.tlast;  obs_fd = o_frame_done;
        chk("tvalid", obs_tv, q.size() > 0);
        if (q.size() > 0) begin
            chk("tdata", obs_td, q[0].d);
            chk("tuser", obs_tu, q[0].u);
            chk("tlast", obs_tl, q[0].l);
            chk("frame_done", obs_fd, r && q[0].e);
        end else begin
            chk("frame_done_idle", obs_fd, 0);
        end
        chk("overflow", o_overflow, m_ovf);
        if (obs_tv && r) begin
            beat_t g;
            g.d = obs_td; g.u = obs_tu; g.l = obs_tl; g.e = obs_fd;
            got.push_back(g);
        end
        model_step(v, s, d, r);
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        i_reset = 1; i_data_valid = 0; i_start_of_frame = 0; i_data = '0; m_axis.tready = 1;
        @(negedge i_clk);
        chk("rst_tvalid", m_axis.tvalid, 0);
        chk("rst_tdata", m_axis.tdata, 0);
        chk("rst_tuser", m_axis.tuser, 0);
        chk("rst_tlast", m_axis.tlast, 0);
        chk("rst_overflow", o_overflow, 0);
        chk("rst_frame_done", o_frame_done, 0);
        i_reset = 0;
        q.delete(); got.delete();
        m_pos = 0; m_stream = 0; m_ovf = 0;
        m_w = (IMAGE_WIDTH == 0) ? 1 : int'(IMAGE_WIDTH);
        m_h = (IMAGE_HEIGHT == 0) ? 1 : int'(IMAGE_HEIGHT);
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) cyc(0, 0, 8'h00, r);
    endtask

    initial begin
        // basic frame W=4 H=2: output lags input by one cycle
        for (int i = 0; i < 10; i++) begin
            tbl[i].v  = (i < 8);
            tbl[i].s  = (i == 0);
            tbl[i].d  = (i < 8) ? 8'(i + 1) : 8'd0;
            tbl[i].tv = (i >= 1) && (i <= 8);
            tbl[i].td = 8'(i);
            tbl[i].tu = (i == 1);
            tbl[i].tl = (i == 4) || (i == 8);
            tbl[i].fd = (i == 8);
        end

        @(negedge i_clk);
        IMAGE_WIDTH = 4; IMAGE_HEIGHT = 2;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].v, tbl[i].s, tbl[i].d, 1);
            chk("tbl_tvalid", obs_tv, tbl[i].tv);
            chk("tbl_frame_done", obs_fd, tbl[i].fd);
            if (tbl[i].tv) begin
                chk("tbl_tdata", obs_td, tbl[i].td);
                chk("tbl_tuser", obs_tu, tbl[i].tu);
                chk("tbl_tlast", obs_tl, tbl[i].tl);
            end
        end
        // back in IDLE: a non-SOF pixel must vanish
        cyc(1, 0, 8'd99, 1);
        idle(2, 1);
        chk("idle_discard_tvalid", obs_tv, 0);

        // sink stalls 10 cycles mid-line: head held, nothing lost
        cyc(1, 1, 8'd10, 1);
        cyc(1, 0, 8'd11, 1);
        for (int i = 0; i < 10; i++) begin
            cyc(i < 2, 0, 8'(12 + i), 0);
            chk("hold_tvalid", obs_tv, 1);
            chk("hold_tdata", obs_td, 11);
            chk("hold_tuser", obs_tu, 0);
            chk("hold_tlast", obs_tl, 0);
        end
        for (int i = 0; i < 4; i++) cyc(1, 0, 8'(14 + i), 1);
        idle(6, 1);
        chk("stall_beats", got.size(), 16);

        // overflow: 6 pixels into a 4-deep buffer with the sink stalled
        do_reset();
        for (int i = 0; i < 6; i++) cyc(1, i == 0, 8'(21 + i), 0);
        idle(3, 0);
        chk("ovf_set", o_overflow, 1);
        cyc(1, 0, 8'd27, 1);
        cyc(1, 0, 8'd28, 1);
        idle(6, 1);
        chk("ovf_sticky", o_overflow, 1);
        chk("ovf_beats", got.size(), 6);
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            chk("ovf_data", got[i].d, e34[i]);
            chk("ovf_tlast", got[i].l, l34[i]);
        end
        if (got.size() == 6) chk("ovf_done_last", got[5].e, 1);

        // leading pixels without SOF are ignored and do not flag overflow
        IMAGE_WIDTH = 2; IMAGE_HEIGHT = 1;
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, 0, 8'(1 + i), 1);
        chk("pre_sof_tvalid", obs_tv, 0);
        cyc(1, 1, 8'd40, 1);
        cyc(1, 0, 8'd41, 1);
        idle(2, 1);
        chk("pre_sof_beats", got.size(), 2);
        if (got.size() > 0) begin
            chk("pre_sof_first", got[0].d, 40);
            chk("pre_sof_tuser", got[0].u, 1);
        end
        chk("pre_sof_ovf", o_overflow, 0);

        // SOF at column 2 restarts the frame; truncated line has no tlast
        IMAGE_WIDTH = 4; IMAGE_HEIGHT = 2;
        do_reset();
        cyc(1, 1, 8'd50, 1);
        cyc(1, 0, 8'd51, 1);
        cyc(1, 0, 8'd52, 1);
        for (int i = 0; i < 8; i++) cyc(1, i == 0, 8'(60 + i), 1);
        idle(2, 1);
        chk("restart_beats", got.size(), 11);
        if (got.size() == 11) begin
            chk("restart_trunc_tlast", got[2].l, 0);
            chk("restart_tuser", got[3].u, 1);
            chk("restart_tdata", got[3].d, 60);
            chk("restart_tlast", got[6].l, 1);
            chk("restart_done", got[10].e, 1);
        end

        // reset with three buffered beats, then a clean frame
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, i == 0, 8'(70 + i), 0);
        chk("pre_rst_tvalid", m_axis.tvalid, 1);
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1, i == 0, 8'(80 + i), 1);
        idle(2, 1);
        chk("post_rst_beats", got.size(), 8);
        if (got.size() > 0) chk("post_rst_sof", got[0].u, 1);

        // randomized traffic across geometries including zero width/height
        for (int c = 0; c < 8; c++) begin
            IMAGE_WIDTH  = 13'($urandom_range(0, 5));
            IMAGE_HEIGHT = 13'($urandom_range(0, 3));
            do_reset();
            for (int n = 0; n < 500; n++) begin
                bit v, s, r;
                v = $urandom_range(0, 3) != 0;
                s = v && (m_stream ? ($urandom_range(0, 30) == 0) : ($urandom_range(0, 2) == 0));
                r = (c % 2) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 5) != 0);
                cyc(v, s, 8'($urandom), r);
            end
            idle(6, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
